// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer: command and FSM state encodings,
// iteration limits, and the ALU opcode mnemonics (op_mne) used on ALU_OP.
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

  // ALU opcode mnemonics driven onto the ALU OP port.
  // kADD must stay 0 so that the idle / reset ALU drive is all zeros.
  typedef enum logic [2:0] {
    kADD  = 3'd0,
    kSUB  = 3'd1,
    kAND  = 3'd2,
    kOR   = 3'd3,
    kXOR  = 3'd4,
    kSLL  = 3'd5,
    kSRL  = 3'd6,
    kPASS = 3'd7
  } op_mne;

  typedef enum logic [1:0] {
    CMD_RLZ = 2'd0,
    CMD_SEQ = 2'd1,
    CMD_DIV = 2'd2,
    CMD_BAD = 2'd3
  } seq_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  // Maximum number of left shifts for normalize-left.
  localparam int kRlzMax    = 8;
  // Number of 4-bit window positions examined by the pattern count.
  localparam int kSeqChecks = 5;

endpackage

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle initiator for a combinational ALU. Implements normalize-left
// (RLZ), 4-bit pattern count (SEQ) and repeated-subtraction divide (DIV) by
// issuing one ALU micro-op per RUN cycle and capturing the ALU result on the
// same clock edge.
//
// Ports:
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   START, CMD          command strobe (accepted in IDLE only) and opcode
//   OPA, OPB, PAT       operands / divisor / SEQ pattern, sampled on START
//   ALU_OP/CI/A/B       drive to the ALU (combinational from state + work)
//   ALU_OUT/CO/ZERO     ALU result, carry/borrow, zero flag (unused here)
//   BUSY, DONE          busy in RUN and DONE, one-cycle completion pulse
//   RESULT, COUNT, ERR  completion values, held until the next command ends
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W    = 8,
  parameter int NCHK = 5
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START,
  input  logic [1:0]   CMD,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic [3:0]   PAT,
  output logic [2:0]   ALU_OP,
  output logic         ALU_CI,
  output logic [W-1:0] ALU_A,
  output logic [W-1:0] ALU_B,
  input  logic [W-1:0] ALU_OUT,
  input  logic         ALU_CO,
  input  logic         ALU_ZERO,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] RESULT,
  output logic [W-1:0] COUNT,
  output logic         ERR
);

  seq_state_t  r_state, w_state_next;
  seq_cmd_t    r_cmd,   w_cmd_next;
  logic [W-1:0] r_work,   w_work_next;
  logic [W-1:0] r_cnt,    w_cnt_next;
  logic [W-1:0] r_opb,    w_opb_next;
  logic [3:0]   r_pat,    w_pat_next;
  logic [2:0]   r_step,   w_step_next;
  logic [W-1:0] r_result, w_result_next;
  logic [W-1:0] r_count,  w_count_next;
  logic         r_err,    w_err_next;

  logic [W-1:0] w_seq_cnt;
  logic         w_unused_zero;

  // The zero flag is only of interest to external monitors.
  assign w_unused_zero = ALU_ZERO;

  // Match count including the window currently being examined.
  assign w_seq_cnt = r_cnt + {{(W-1){1'b0}}, (r_work[3:0] == r_pat)};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_cmd    <= CMD_RLZ;
      r_work   <= '0;
      r_cnt    <= '0;
      r_opb    <= '0;
      r_pat    <= '0;
      r_step   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cmd    <= w_cmd_next;
      r_work   <= w_work_next;
      r_cnt    <= w_cnt_next;
      r_opb    <= w_opb_next;
      r_pat    <= w_pat_next;
      r_step   <= w_step_next;
      r_result <= w_result_next;
      r_count  <= w_count_next;
      r_err    <= w_err_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cmd_next    = r_cmd;
    w_work_next   = r_work;
    w_cnt_next    = r_cnt;
    w_opb_next    = r_opb;
    w_pat_next    = r_pat;
    w_step_next   = r_step;
    w_result_next = r_result;
    w_count_next  = r_count;
    w_err_next    = r_err;
    ALU_OP        = kADD;
    ALU_CI        = 1'b0;
    ALU_A         = '0;
    ALU_B         = '0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_next = S_RUN;
          w_cmd_next   = seq_cmd_t'(CMD);
          w_work_next  = OPA;
          w_cnt_next   = '0;
          w_opb_next   = OPB;
          w_pat_next   = PAT;
          w_step_next  = '0;
        end
      end

      S_RUN: begin
        case (r_cmd)
          CMD_RLZ: begin
            ALU_OP = kSLL;
            ALU_A  = r_work;
            if (r_work[W-1] || (r_cnt == W'(kRlzMax))) begin
              w_state_next  = S_DONE;
              w_result_next = r_work;
              w_count_next  = r_cnt;
              w_err_next    = 1'b0;
            end else begin
              w_work_next = ALU_OUT;
              w_cnt_next  = r_cnt + 1'b1;
            end
          end

          CMD_SEQ: begin
            ALU_OP      = kSRL;
            ALU_A       = r_work;
            w_work_next = ALU_OUT;
            w_cnt_next  = w_seq_cnt;
            w_step_next = r_step + 1'b1;
            // On the last window the shifted word is already OPA >> NCHK.
            if (r_step == 3'(NCHK - 1)) begin
              w_state_next  = S_DONE;
              w_result_next = ALU_OUT;
              w_count_next  = w_seq_cnt;
              w_err_next    = 1'b0;
            end
          end

          CMD_DIV: begin
            ALU_OP = kSUB;
            ALU_A  = r_work;
            ALU_B  = r_opb;
            if (r_opb == '0) begin
              w_state_next  = S_DONE;
              w_result_next = '1;
              w_count_next  = '1;
              w_err_next    = 1'b1;
            end else if (!ALU_CO) begin
              w_work_next = ALU_OUT;
              w_cnt_next  = r_cnt + 1'b1;
            end else begin
              // Borrow: the current work value is the remainder.
              w_state_next  = S_DONE;
              w_result_next = r_work;
              w_count_next  = r_cnt;
              w_err_next    = 1'b0;
            end
          end

          default: begin
            w_state_next  = S_DONE;
            w_result_next = '0;
            w_count_next  = '0;
            w_err_next    = 1'b1;
          end
        endcase
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign BUSY   = (r_state != S_IDLE);
  assign DONE   = (r_state == S_DONE);
  assign RESULT = r_result;
  assign COUNT  = r_count;
  assign ERR    = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Bench for alu_sequencer with a behavioural ALU attached to its ALU port and
// an arithmetic reference model for the expected RESULT/COUNT/ERR/latency.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       START = 1'b0;
  logic [1:0] CMD = 2'd0;
  logic [7:0] OPA = 8'd0;
  logic [7:0] OPB = 8'd0;
  logic [3:0] PAT = 4'd0;
  logic [2:0] ALU_OP;
  logic       ALU_CI;
  logic [7:0] ALU_A, ALU_B, ALU_OUT;
  logic       ALU_CO, ALU_ZERO;
  logic       BUSY, DONE, ERR;
  logic [7:0] RESULT, COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  alu_sequencer #(.W(8), .NCHK(5)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .CMD(CMD),
    .OPA(OPA), .OPB(OPB), .PAT(PAT),
    .ALU_OP(ALU_OP), .ALU_CI(ALU_CI), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OUT(ALU_OUT), .ALU_CO(ALU_CO), .ALU_ZERO(ALU_ZERO),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUNT(COUNT), .ERR(ERR)
  );

  // Behavioural combinational ALU: shifts move by one bit, SUB flags borrow.
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    case (ALU_OP)
      kADD:    t = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CI};
      kSUB:    t = {1'b0, ALU_A} - {1'b0, ALU_B};
      kSLL:    t = {ALU_A, 1'b0};
      kSRL:    t = {ALU_A[0], 1'b0, ALU_A[7:1]};
      default: t = 9'd0;
    endcase
    ALU_OUT  = t[7:0];
    ALU_CO   = t[8];
    ALU_ZERO = (t[7:0] == 8'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected outputs and number of RUN cycles.
  task automatic ref_model(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] p, output logic [7:0] res, output logic [7:0] cnt,
                           output logic e, output int nrun);
    int n;
    int m;
    e = 1'b0;
    case (cmd)
      2'd0: begin
        if (a == 8'd0) begin
          res = 8'd0; cnt = 8'd8; nrun = 9;
        end else begin
          n = 0;
          while (a[7-n] == 1'b0) n++;
          res = a << n; cnt = 8'(n); nrun = n + 1;
        end
      end
      2'd1: begin
        m = 0;
        for (int i = 0; i < 5; i++)
          if (((a >> i) & 8'h0F) == {4'd0, p}) m++;
        res = a >> 5; cnt = 8'(m); nrun = 5;
      end
      2'd2: begin
        if (b == 8'd0) begin
          res = 8'hFF; cnt = 8'hFF; e = 1'b1; nrun = 1;
        end else begin
          res = a % b; cnt = a / b; nrun = int'(a / b) + 1;
        end
      end
      default: begin
        res = 8'd0; cnt = 8'd0; e = 1'b1; nrun = 1;
      end
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] p, input bit busy_poke);
    logic [7:0] er, ec;
    logic       ee;
    int         nrun;
    int         lat;
    ref_model(cmd, a, b, p, er, ec, ee, nrun);
    @(negedge CLK);
    CMD = cmd; OPA = a; OPB = b; PAT = p; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 1;
    check("busy_on_start", 32'(BUSY), 32'd1);
    while (!DONE && lat < 300) begin
      // A second strobe while busy must leave the running command untouched.
      if (busy_poke && nrun >= 3 && lat == 3) begin
        START = 1'b1; CMD = 2'($urandom); OPA = 8'($urandom); OPB = 8'($urandom);
        PAT = 4'($urandom);
      end else begin
        START = 1'b0;
      end
      check("alu_ci", 32'(ALU_CI), 32'd0);
      @(posedge CLK); #1;
      lat++;
    end
    START = 1'b0;
    check("done_seen", 32'(DONE), 32'd1);
    check("latency", 32'(lat), 32'(nrun + 1));
    check("result", 32'(RESULT), 32'(er));
    check("count", 32'(COUNT), 32'(ec));
    check("err", 32'(ERR), 32'(ee));
    check("busy_in_done", 32'(BUSY), 32'd1);
    check("alu_op_done", 32'(ALU_OP), 32'(kADD));
    check("alu_a_done", 32'(ALU_A), 32'd0);
    $display("txn cmd=%0d a=%02h b=%02h pat=%h poke=%0b -> result=%02h count=%02h err=%0b lat=%0d",
             cmd, a, b, p, busy_poke, RESULT, COUNT, ERR, lat);
    // Strobe during the DONE cycle must not start a new command.
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("idle_after_done", 32'(BUSY), 32'd0);
    check("done_one_cycle", 32'(DONE), 32'd0);
    @(posedge CLK); #1;
    check("still_idle", 32'(BUSY), 32'd0);
    check("result_hold", 32'(RESULT), 32'(er));
    check("count_hold", 32'(COUNT), 32'(ec));
    check("alu_b_idle", 32'(ALU_B), 32'd0);
  endtask

  initial begin
    logic [1:0] rc;
    logic [7:0] ra, rb;
    logic [3:0] rp;

    #2 RESET_N = 1'b0;
    #10;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_alu", {24'd0, ALU_OP, ALU_CI, 4'd0}, 32'd0);
    check("rst_alu_ab", {16'd0, ALU_A, ALU_B}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Directed cases.
    run_cmd(2'd0, 8'h01, 8'h00, 4'h0, 1'b0);
    run_cmd(2'd0, 8'h00, 8'h00, 4'h0, 1'b0);
    run_cmd(2'd0, 8'h80, 8'h00, 4'h0, 1'b0);
    run_cmd(2'd1, 8'hAA, 8'h00, 4'hA, 1'b0);
    run_cmd(2'd1, 8'hFF, 8'h00, 4'hF, 1'b0);
    run_cmd(2'd2, 8'd200, 8'd7, 4'h0, 1'b0);
    run_cmd(2'd2, 8'd200, 8'd7, 4'h0, 1'b1);
    run_cmd(2'd2, 8'd255, 8'd1, 4'h0, 1'b0);
    run_cmd(2'd2, 8'd5, 8'd9, 4'h0, 1'b0);
    run_cmd(2'd2, 8'd77, 8'd0, 4'h0, 1'b0);
    run_cmd(2'd3, 8'h55, 8'h12, 4'h3, 1'b0);

    // Reset in the middle of a divide: immediate clear, no DONE pulse.
    @(negedge CLK);
    CMD = 2'd2; OPA = 8'd200; OPB = 8'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_vals", {15'd0, ERR, RESULT, COUNT}, 32'd0);
    check("mid_rst_alu", {13'd0, ALU_OP, ALU_A, ALU_B}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("mid_rst_no_done", 32'(DONE), 32'd0);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    run_cmd(2'd0, 8'h40, 8'h00, 4'h0, 1'b0);

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      rc = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rp = 4'($urandom);
      if (rc == 2'd1 && $urandom_range(0, 1) == 1) rp = ra[3:0];
      run_cmd(rc, ra, rb, rp, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
